// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        LOAD,
        DRAIN,
        RUN,
        ERR
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'hE1A00000;

endpackage

// File: rtl/imem_loader_ctrl_word_assembler.sv
// Packs an accepted byte stream little-endian into 32-bit words; word_valid_o
// pulses combinationally with the handshake of the lane-3 byte.
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  lane_q, lane_d;
    logic [23:0] pack_q, pack_d;

    // Bytes shift in from the top so lane 0 ends up in bits [7:0].
    always_comb begin
        lane_d = lane_q;
        pack_d = pack_q;
        if (clear_i) begin
            lane_d = '0;
            pack_d = '0;
        end else if (byte_valid_i) begin
            lane_d = lane_q + 2'd1;
            pack_d = {byte_i, pack_q[23:8]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q <= '0;
            pack_q <= '0;
        end else begin
            lane_q <= lane_d;
            pack_q <= pack_d;
        end
    end

    assign word_valid_o = byte_valid_i && (lane_q == 2'd3);
    assign word_o       = {byte_i, pack_q};

endmodule

// File: rtl/imem_loader_ctrl.sv
// Boot-load controller: packs loader bytes into instruction memory, holds the
// core in reset until the image is complete. Optional: IMEM_LOADER_CHECKSUM_EN.
module imem_loader_ctrl
    import imem_loader_pkg::*;
#(
    parameter int unsigned WORDS = 32,
    parameter int unsigned AW    = $clog2(WORDS),
    parameter logic [31:0] NOP   = NOP_INSTR
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          load_done,
    input  logic          reload,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   cpu_addr,
    output logic [AW-1:0] mem_raddr,
    input  logic [31:0]   mem_rdata,
    output logic [31:0]   instr,
    output logic          cpu_reset,
    output logic [AW:0]   words_loaded,
    output logic          err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [AW:0] FINAL_IDX = (AW+1)'(WORDS);
`else
    localparam logic [AW:0] FINAL_IDX = (AW+1)'(WORDS - 1);
`endif
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    state_e        state_q, state_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [AW:0]   count_q, count_d;
    logic          cpu_reset_q;

    logic          accept;
    logic          word_valid;
    logic [31:0]   word;
    logic          word_is_final;
    logic          word_is_cks;
    logic          cks_bad;
    logic          reload_go;
    logic          asm_clear;
    logic          unused_addr_bits;

    assign accept        = in_valid && in_ready;
    assign word_is_final = (count_q == FINAL_IDX);
    assign reload_go     = reload && ((state_q == RUN) || (state_q == ERR));
    assign asm_clear     = reload_go || ((state_q == LOAD) && (state_d != LOAD));

    word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (asm_clear),
        .byte_valid_i (accept),
        .byte_i       (in_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:     if (load_done || (word_valid && word_is_final)) state_d = DRAIN;
            DRAIN:    state_d = cks_bad ? ERR : RUN;
            RUN, ERR: if (reload) state_d = LOAD;
            default:  state_d = LOAD;
        endcase
    end

    // Write register: a completed word is written the cycle after its last byte.
    always_comb begin
        mem_we_d = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        count_d  = count_q;
        if (reload_go) begin
            count_d = '0;
        end else if (word_valid && !word_is_cks) begin
            mem_we_d = 1'b1;
            waddr_d  = count_q[AW-1:0];
            wdata_d  = word;
            count_d  = count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD;
            mem_we_q    <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            count_q     <= '0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            count_q     <= count_d;
            cpu_reset_q <= (state_d != RUN);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
    logic [31:0] cks_q, cks_d;
    logic        cks_seen_q, cks_seen_d;
    logic        err_q;

    assign word_is_cks = word_is_final;
    // An image cut short by load_done never sees its checksum and is trusted.
    assign cks_bad     = cks_seen_q && (sum_q != cks_q);

    always_comb begin
        sum_d      = sum_q;
        cks_d      = cks_q;
        cks_seen_d = cks_seen_q;
        if (reload_go) begin
            sum_d      = '0;
            cks_seen_d = 1'b0;
        end else if (word_valid) begin
            if (word_is_cks) begin
                cks_d      = word;
                cks_seen_d = 1'b1;
            end else begin
                sum_d = sum_q + word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q      <= '0;
            cks_q      <= '0;
            cks_seen_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            cks_q      <= cks_d;
            cks_seen_q <= cks_seen_d;
            err_q      <= (state_d == ERR);
        end
    end

    assign err = err_q;
`else
    assign word_is_cks = 1'b0;
    assign cks_bad     = 1'b0;
    assign err         = 1'b0;
`endif

    assign unused_addr_bits = ^{cpu_addr[31:AW+2], cpu_addr[1:0]};

    assign in_ready     = (state_q == LOAD);
    assign mem_we       = mem_we_q;
    assign mem_waddr    = waddr_q;
    assign mem_wdata    = wdata_q;
    assign mem_raddr    = cpu_addr[AW+1:2];
    assign instr        = (state_q == RUN) ? mem_rdata : NOP;
    assign cpu_reset    = cpu_reset_q;
    assign words_loaded = count_q;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Self-checking bench for imem_loader_ctrl (WORDS=4); adapts to IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader_ctrl;

    localparam int unsigned WORDS = 4;
    localparam int unsigned AW    = 2;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CKS = 1'b1;
`else
    localparam bit CKS = 1'b0;
`endif
    localparam int unsigned IMG_WORDS = WORDS + (CKS ? 1 : 0);
    localparam logic [31:0] NOPV = 32'hE1A00000;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          load_done;
    logic          reload;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [31:0]   cpu_addr;
    logic [AW-1:0] mem_raddr;
    logic [31:0]   mem_rdata;
    logic [31:0]   instr;
    logic          cpu_reset;
    logic [AW:0]   words_loaded;
    logic          err;

    always #5 clk = ~clk;

    imem_loader_ctrl #(.WORDS(WORDS), .AW(AW), .NOP(NOPV)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .load_done    (load_done),
        .reload       (reload),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .cpu_addr     (cpu_addr),
        .mem_raddr    (mem_raddr),
        .mem_rdata    (mem_rdata),
        .instr        (instr),
        .cpu_reset    (cpu_reset),
        .words_loaded (words_loaded),
        .err          (err)
    );

    // Instruction memory the DUT writes into; read port is combinational.
    logic [31:0] tb_mem [WORDS];
    assign mem_rdata = tb_mem[mem_raddr];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         wr_q[$];
    logic        prev_we = 1'b0;
    int unsigned bb_viol = 0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) tb_mem[i] <= 32'hA5A50000 + 32'(i);
            prev_we <= 1'b0;
        end else begin
            if (mem_we) begin
                tb_mem[mem_waddr] <= mem_wdata;
                wr_q.push_back('{mem_waddr, mem_wdata});
            end
            if (mem_we && prev_we) bb_viol <= bb_viol + 1;
            prev_we <= mem_we;
        end
    end

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [7:0]  img [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_word(input int k);
        return {img[4*k+3], img[4*k+2], img[4*k+1], img[4*k]};
    endfunction

    typedef struct {
        logic [31:0]   addr;
        bit            in_run;
        logic [AW-1:0] exp_raddr;
        logic [31:0]   exp_instr;
    } fetch_vec_t;

    fetch_vec_t vt [8];

    task automatic apply_table(input bit run_phase);
        for (int i = 0; i < 8; i++) begin
            if (vt[i].in_run == run_phase) begin
                cpu_addr = vt[i].addr;
                #1;
                check($sformatf("tbl%0d_raddr", i), 32'(mem_raddr), 32'(vt[i].exp_raddr));
                check($sformatf("tbl%0d_instr", i), instr, vt[i].exp_instr);
            end
        end
    endtask

    task automatic do_reload();
        reload = 1'b1;
        step();
        reload = 1'b0;
        check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
        check("reload_in_ready", 32'(in_ready), 32'd1);
        check("reload_words_loaded", 32'(words_loaded), 32'd0);
        check("reload_err", 32'(err), 32'd0);
    endtask

    // mode 0: full image; mode 1: n bytes then a separate load_done; mode 2: load_done with byte n-1.
    task automatic run_load(input int n, input int mode, input bit gaps, input bit bad_cks);
        int          nwords;
        bit          exp_err;
        bit          exp_we;
        int          idx;
        logic [31:0] cks;
        logic [31:0] exp_instr;

        wr_q.delete();
        if (mode == 0 && CKS) begin
            cks = 32'(bad_cks);
            for (int k = 0; k < WORDS; k++) cks = cks + model_word(k);
            img[4*WORDS]   = cks[7:0];
            img[4*WORDS+1] = cks[15:8];
            img[4*WORDS+2] = cks[23:16];
            img[4*WORDS+3] = cks[31:24];
        end

        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    step();
                end
            end
            in_valid  = 1'b1;
            in_data   = img[i];
            load_done = (mode == 2) && (i == n - 1);
            check($sformatf("byte%0d_in_ready", i), 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        if (mode == 1) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            load_done = 1'b1;
            check("done_in_ready", 32'(in_ready), 32'd1);
            step();
        end
        load_done = 1'b0;

        nwords  = (n / 4 < WORDS) ? n / 4 : WORDS;
        exp_we  = (mode == 0 && !CKS) || (mode == 2 && n > 0 && n % 4 == 0);
        exp_err = CKS && mode == 0 && bad_cks;

        check("drain_in_ready", 32'(in_ready), 32'd0);
        check("drain_cpu_reset", 32'(cpu_reset), 32'd1);
        check("drain_mem_we", 32'(mem_we), 32'(exp_we));
        step();
        check("end_cpu_reset", 32'(cpu_reset), 32'(exp_err));
        check("end_err", 32'(err), 32'(exp_err));
        check("end_mem_we", 32'(mem_we), 32'd0);
        check("end_in_ready", 32'(in_ready), 32'd0);

        check("write_count", wr_q.size(), 32'(nwords));
        for (int k = 0; k < wr_q.size() && k < nwords; k++) begin
            check($sformatf("write%0d_addr", k), 32'(wr_q[k].addr), 32'(k));
            check($sformatf("write%0d_data", k), wr_q[k].data, model_word(k));
        end
        check("words_loaded", 32'(words_loaded), 32'(nwords));

        cpu_addr = $urandom;
        #1;
        idx = int'((cpu_addr / 4) % WORDS);
        exp_instr = exp_err ? NOPV : ((idx < nwords) ? model_word(idx) : tb_mem[idx]);
        check("fetch_raddr", 32'(mem_raddr), 32'(idx));
        check("fetch_instr", instr, exp_instr);
    endtask

    initial begin
        vt[0] = '{32'h00000008, 1'b0, 2'd2, NOPV};
        vt[1] = '{32'h00000000, 1'b0, 2'd0, NOPV};
        vt[2] = '{32'hFFFFFFFC, 1'b0, 2'd3, NOPV};
        vt[3] = '{32'h00000000, 1'b1, 2'd0, 32'h03020100};
        vt[4] = '{32'h0000000C, 1'b1, 2'd3, 32'h0F0E0D0C};
        vt[5] = '{32'h00000006, 1'b1, 2'd1, 32'h07060504};
        vt[6] = '{32'hFFFFFFF8, 1'b1, 2'd2, 32'h0B0A0908};
        vt[7] = '{32'h00000013, 1'b1, 2'd0, 32'h03020100};

        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        load_done = 1'b0;
        reload    = 1'b0;
        cpu_addr  = 32'd8;
        for (int i = 0; i < 64; i++) img[i] = 8'(i);
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_waddr", 32'(mem_waddr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_words_loaded", 32'(words_loaded), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_instr", instr, NOPV);
        check("rst_mem_raddr", 32'(mem_raddr), 32'd2);
        reset = 1'b0;
        step();

        apply_table(1'b0);
        run_load(4 * IMG_WORDS, 0, 1'b0, 1'b0);
        apply_table(1'b1);

        // Bytes and load_done are ignored while running.
        in_valid  = 1'b1;
        load_done = 1'b1;
        in_data   = 8'h55;
        #1;
        check("run_in_ready", 32'(in_ready), 32'd0);
        step();
        in_valid  = 1'b0;
        load_done = 1'b0;
        check("run_cpu_reset", 32'(cpu_reset), 32'd0);
        check("run_mem_we", 32'(mem_we), 32'd0);
        check("run_words_loaded", 32'(words_loaded), 32'(WORDS));

        do_reload();
        apply_table(1'b0);
        run_load(6, 1, 1'b0, 1'b0);
        do_reload();
        run_load(4, 2, 1'b0, 1'b0);

        // Reset in the middle of a load.
        do_reload();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = img[i];
            step();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_words_loaded", 32'(words_loaded), 32'd0);
        check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("midrst_mem_wdata", mem_wdata, 32'd0);
        for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
        run_load(4 * IMG_WORDS, 0, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_reload();
        run_load(4 * IMG_WORDS, 0, 1'b0, 1'b1);
        check("cks_err_instr", instr, NOPV);
        do_reload();
        run_load(4 * IMG_WORDS, 0, 1'b1, 1'b0);
`endif

        for (int it = 0; it < 24; it++) begin
            int mode;
            int n;
            do_reload();
            for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
            mode = int'($urandom_range(0, 2));
            if (mode == 0)      n = 4 * IMG_WORDS;
            else if (mode == 1) n = int'($urandom_range(0, 4 * WORDS - 1));
            else                n = int'($urandom_range(1, 4 * WORDS - 1));
            run_load(n, mode, 1'($urandom_range(0, 1)), CKS ? 1'($urandom_range(0, 1)) : 1'b0);
        end

        check("no_back_to_back_we", bb_viol, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_loader_ctrl.md
# imem_loader_ctrl

Boot-load controller for the instruction memory of the single-cycle ARM core. It accepts a byte stream from the host loader and packs it little-endian into 32-bit words. It drives the instruction-memory write port and holds the core in reset until the program image is complete. In RUN it forwards fetch reads untouched; in every other state it feeds the core a NOP.

## Interface
Parameters:
- WORDS, 32, instruction-memory depth in words; image length when no early done
- AW, 5, word-address width, $clog2(WORDS)
- NOP, 32'hE1A00000, instruction returned while not in RUN (MOV r0,r0)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_data  in  8  loader byte
- in_valid  in  1  byte present
- in_ready  out  1  byte accepted when in_valid && in_ready
- load_done  in  1  one-cycle pulse, ends the image early
- reload  in  1  one-cycle pulse, restarts loading from RUN/ERR
- mem_we  out  1  instruction-memory write strobe
- mem_waddr  out  AW  write word address
- mem_wdata  out  32  write data
- cpu_addr  in  32  core fetch byte address (PC)
- mem_raddr  out  AW  = cpu_addr[AW+1:2], always
- mem_rdata  in  32  memory read data (combinational)
- instr  out  32  to core: mem_rdata in RUN, else NOP
- cpu_reset  out  1  holds core in reset
- words_loaded  out  AW+1  words written this load
- err  out  1  checksum failure (see Configuration)

## Operation
- States: LOAD, DRAIN, RUN, ERR (ERR only with the macro).
- Reset: state LOAD; byte lane 0; word count 0; mem_we 0; mem_waddr 0; mem_wdata 0; cpu_reset 1; words_loaded 0; err 0.
- in_ready = (state == LOAD). This combinational output does not depend on in_valid.
- Byte lane k (0..3) goes to bits [8k+7:8k]. Accepting lane 3 completes a word, and the lane wraps to 0.
- Completed word: registered write next cycle. mem_we=1, mem_waddr=word count, mem_wdata=word. Count and words_loaded increment in that write cycle.
- LOAD→DRAIN when the completed word is word WORDS-1 (the checksum word with the macro), or when load_done=1.
- load_done in the same cycle as a lane-3 byte: the byte is accepted and its word is written in DRAIN. Partial lanes 0–2 are discarded.
- DRAIN: performs any pending write, then →RUN next cycle. Never accepts bytes.
- RUN: cpu_reset=0, instr=mem_rdata. Bytes are refused. load_done is ignored.
- reload in RUN or ERR: →LOAD next cycle. Count, lane and words_loaded are cleared; cpu_reset=1. reload in LOAD or DRAIN is ignored.
- reset mid-load: returns to the reset state immediately. Partially written memory contents are left as they are.

## Timing
- Byte-to-write latency: 1 cycle after the lane-3 handshake.
- Back-to-back bytes are accepted every cycle. A write overlaps acceptance of the next word's lane 0.
- cpu_reset and state are registered. cpu_reset falls on the first RUN cycle, 2 cycles after the final lane-3 handshake.
- instr switches combinationally with state. The fetch path adds no latency: it is a mux only.
- mem_we is never high for two consecutive cycles. This follows because 4 bytes are needed per word.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - The image is WORDS data words followed by 1 checksum word, which equals the mod-2^32 sum of the data words.
  - The checksum word is not written to memory.
  - A running sum clears on entry to LOAD.
  - In DRAIN the sum is compared with the checksum word. Match →RUN. Mismatch →ERR, with err=1 and cpu_reset=1.
  - load_done ends the image without a checksum comparison, and the block goes to RUN.
- Undefined: no sum register, no ERR state. err is tied to 0, and the image is exactly WORDS words.

## Structure
- Package imem_loader_pkg: state enum (LOAD, DRAIN, RUN, ERR) and the NOP_INSTR constant.
- Sub-module word_assembler: byte lane counter and 32-bit shift/pack register. It exposes a word_valid pulse and a clear input.
- The top level holds the FSM, write register, checksum, and fetch mux.

## Test plan
- Full load, WORDS=4: stream bytes 00..0F on consecutive cycles.
  - Required: 4 writes, with word 0 = 32'h03020100 and word 3 = 32'h0F0E0D0C.
  - Required: cpu_reset falls 2 cycles after byte 0F; instr then equals mem_rdata.
- Early done: 6 bytes, then load_done.
  - Required: 1 write (32'h03020100), words_loaded=1, bytes 4–5 discarded, RUN 2 cycles later.
- load_done with the 4th byte (byte 03):
  - Required: the word is written in DRAIN, and in_ready=0 from the next cycle.
- During LOAD, cpu_addr=8: instr=32'hE1A00000 and mem_raddr=2.
- reload in RUN: cpu_reset=1 next cycle. A second image overwrites from address 0, and words_loaded restarts at 0.
- Checksum (macro on, WORDS=2): words 1 and 2 with checksum 3 → RUN. Checksum 4 → err=1, cpu_reset stays 1. A reload then clears err.
